hbridge_pwm_gen: RTL

HBRIDGE_PWM_GEN -- requirements
Module: hbridge_pwm_gen

---
 rtl/hbridge_pwm_pkg.sv | 26 ++
 rtl/hbridge_pwm_gen_tri_carrier.sv | 116 +++++++++++
 rtl/hbridge_pwm_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/hbridge_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hbridge_pwm_pkg
//  Description : Shared types and constants for the H-bridge PWM generator.
//                Holds the carrier FSM state type, the default counter width
//                and the bit positions of the two legs in igbt_control.
//  Revision    : 1.0  initial release
// ============================================================================
package hbridge_pwm_pkg;

  // Default width of the carrier counter, period and compare values
  localparam int CNT_W_DEFAULT = 16;

  // Bit positions inside igbt_control
  localparam int LEFT_BIT  = 1;   // left upper switch on
  localparam int RIGHT_BIT = 0;   // right upper switch on

  // Triangle carrier state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } carrier_state_e;

endpackage
`default_nettype wire

// File: rtl/hbridge_pwm_gen_tri_carrier.sv
`default_nettype none
// ============================================================================
//  Module      : tri_carrier
//  Description : Up/down triangle carrier with IDLE/UP/DOWN state machine.
//                Counts 0 .. period_act-1 upward, then period_act .. 1
//                downward, giving a carrier of 2*period_act clocks.
//                period_act is sampled on start-up and at every valley.
//  Ports       : clk, rst_n        clock, async active-low reset
//                i_enable          run request
//                i_period          triangle peak value
//                i_sync            phase-alignment strobe
//                i_phase_offset    counter value loaded on i_sync
//                o_state           current carrier state
//                o_cnt             current counter value
//                o_zero / o_peak   single-cycle valley / peak marks
//                o_cfg_bad         period is too small to run (< 2)
//  Revision    : 1.0  initial release
// ============================================================================
module tri_carrier
  import hbridge_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_sync,
  input  logic [CNT_W-1:0] i_phase_offset,
  output carrier_state_e   o_state,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero,
  output logic             o_peak,
  output logic             o_cfg_bad
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two = CNT_W'(2);

  carrier_state_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_act;
  logic             r_zero;
  logic             r_peak;

  logic             w_cfg_bad;
  logic [CNT_W-1:0] w_sync_val;

  assign w_cfg_bad  = (i_period < c_two);
  // A sync load never places the counter above the current peak
  assign w_sync_val = (i_phase_offset > r_period_act) ? r_period_act : i_phase_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_period_act <= '0;
      r_zero       <= 1'b0;
      r_peak       <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      r_peak <= 1'b0;
      if (!i_enable || w_cfg_bad) begin
        // period_act is deliberately left alone here
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_UP;
            r_cnt        <= '0;
            r_period_act <= i_period;
          end
          ST_UP: begin
            if (i_sync) begin
              r_state <= ST_UP;
              r_cnt   <= w_sync_val;
            end else if (r_cnt >= (r_period_act - c_one)) begin
              // ">=" also turns around a counter that was sync-loaded at the peak
              r_state <= ST_DOWN;
              r_cnt   <= r_period_act;
              r_peak  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          ST_DOWN: begin
            if (i_sync) begin
              r_state <= ST_UP;
              r_cnt   <= w_sync_val;
            end else if (r_cnt <= c_one) begin
              r_state      <= ST_UP;
              r_cnt        <= '0;
              r_zero       <= 1'b1;
              r_period_act <= i_period;
            end else begin
              r_cnt <= r_cnt - c_one;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_state   = r_state;
  assign o_cnt     = r_cnt;
  assign o_zero    = r_zero;
  assign o_peak    = r_peak;
  assign o_cfg_bad = w_cfg_bad;

endmodule
`default_nettype wire

// File: rtl/hbridge_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : hbridge_pwm_gen
//  Description : Centre-aligned PWM generator for a full H-bridge. A triangle
//                carrier (tri_carrier) is compared against double-buffered
//                left/right compare values to produce the two upper-switch
//                commands for the dead-time/gate stage.
//  Ports       : clk, rst_n        clock, async active-low reset
//                enable            run request
//                period            triangle peak value (clocks per half)
//                cmp_left/right    compare values, written on cmp_valid
//                cmp_valid         strobe writing compares to shadow
//                sync_in           carrier phase-alignment strobe
//                phase_offset      counter value loaded on sync_in
//                igbt_control      [1] left upper on, [0] right upper on
//                carrier_cnt       current carrier counter
//                zero_pulse        valley mark
//                peak_pulse        peak mark
//                cfg_err           period < 2
//  Revision    : 1.0  initial release
// ============================================================================
module hbridge_pwm_gen
  import hbridge_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] cmp_left,
  input  logic [CNT_W-1:0] cmp_right,
  input  logic             cmp_valid,
  input  logic             sync_in,
  input  logic [CNT_W-1:0] phase_offset,
  output logic [1:0]       igbt_control,
  output logic [CNT_W-1:0] carrier_cnt,
  output logic             zero_pulse,
  output logic             peak_pulse,
  output logic             cfg_err
);

  carrier_state_e   w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic             w_peak;
  logic             w_cfg_bad;

  tri_carrier #(
    .CNT_W (CNT_W)
  ) u_tri_carrier (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_period       (period),
    .i_sync         (sync_in),
    .i_phase_offset (phase_offset),
    .o_state        (w_state),
    .o_cnt          (w_cnt),
    .o_zero         (w_zero),
    .o_peak         (w_peak),
    .o_cfg_bad      (w_cfg_bad)
  );

  logic [CNT_W-1:0] r_shadow_left;
  logic [CNT_W-1:0] r_shadow_right;
  logic [CNT_W-1:0] r_act_left;
  logic [CNT_W-1:0] r_act_right;
  logic [1:0]       r_igbt;
  logic             r_cfg_err;

  logic             w_run;
  logic             w_copy;
  logic             w_left_on;
  logic             w_right_on;

  assign w_run  = enable && !w_cfg_bad && (w_state != ST_IDLE);
  assign w_copy = w_zero | w_peak;

  // The down slope compares with ">=" (i.e. against cnt-1), so each count
  // value on the way down pairs with its mirror on the way up. High time is
  // then exactly 2*cmp clocks centred on the valley, cmp = 0 never fires and
  // cmp >= period_act stays high through the peak sample.
  assign w_left_on  = (w_state == ST_UP) ? (r_act_left  > w_cnt) : (r_act_left  >= w_cnt);
  assign w_right_on = (w_state == ST_UP) ? (r_act_right > w_cnt) : (r_act_right >= w_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_left  <= '0;
      r_shadow_right <= '0;
      r_act_left     <= '0;
      r_act_right    <= '0;
      r_igbt         <= 2'b00;
      r_cfg_err      <= 1'b0;
    end else begin
      if (cmp_valid) begin
        r_shadow_left  <= cmp_left;
        r_shadow_right <= cmp_right;
      end
      // Copy on the valley/peak cycle; a strobe in that same cycle bypasses
      // the shadow so the new values take effect without waiting half a carrier.
      if (w_copy) begin
        r_act_left  <= cmp_valid ? cmp_left  : r_shadow_left;
        r_act_right <= cmp_valid ? cmp_right : r_shadow_right;
      end
      r_igbt[LEFT_BIT]  <= w_run & w_left_on;
      r_igbt[RIGHT_BIT] <= w_run & w_right_on;
      r_cfg_err         <= w_cfg_bad;
    end
  end

  assign igbt_control = r_igbt;
  assign carrier_cnt  = w_cnt;
  assign zero_pulse   = w_zero;
  assign peak_pulse   = w_peak;
  assign cfg_err      = r_cfg_err;

endmodule
`default_nettype wire
